// File: rtl/riscv32ima_mem_resp_if.sv
// Core-side memory bus: active-low select/write strobes, bit-masked writes,
// registered read data, stall back-pressure and an out-of-range error pulse.
interface riscv32ima_mem_resp_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic                  ncs;
    logic                  nwe;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] wmask;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  stall;
    logic                  err;

    modport master (output ncs, nwe, addr, wdata, wmask, input rdata, stall, err);
    modport slave  (input ncs, nwe, addr, wdata, wmask, output rdata, stall, err);
endinterface

// File: rtl/riscv32ima_mem_resp.sv
// On-chip word memory responder for one core bus port, with a configurable
// number of stall cycles per access to exercise requester back-pressure.
module riscv32ima_mem_resp #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    DEPTH       = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int                    WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  nrst,
    riscv32ima_mem_resp_if.slave  bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFW  = $clog2(BYTES);
    localparam int IDXW  = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(DEPTH * BYTES);
    localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("riscv32ima_mem_resp: WAIT_CYCLES must be 0..15");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("riscv32ima_mem_resp: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [0:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  stall_q, stall_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  nwe_q, nwe_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] wmask_q, wmask_d;

    logic                  accept;
    logic                  acc_en;
    logic                  acc_nwe;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [DATA_WIDTH-1:0] acc_wmask;
    logic [ADDR_WIDTH-1:0] off;
    logic                  in_rng;
    logic [IDXW-1:0]       idx;
    logic [DATA_WIDTH-1:0] mem_rd;
    logic                  mem_we;

    assign accept = !bus.ncs && !stall_q;

    // Zero-wait mode accesses straight off the bus; otherwise the captured request is used.
    always_comb begin
        acc_en    = ZERO_WAIT ? accept    : (state_q == BUSY && cnt_q == 4'd0);
        acc_nwe   = ZERO_WAIT ? bus.nwe   : nwe_q;
        acc_addr  = ZERO_WAIT ? bus.addr  : addr_q;
        acc_wdata = ZERO_WAIT ? bus.wdata : wdata_q;
        acc_wmask = ZERO_WAIT ? bus.wmask : wmask_q;
    end

    // Lower bound checked first so the subtraction never wraps into range.
    assign off    = acc_addr - BASE_ADDR;
    assign in_rng = (acc_addr >= BASE_ADDR) && ({1'b0, off} < SPAN);
    assign idx    = off[OFFW +: IDXW];
    assign mem_rd = mem[idx];
    assign mem_we = acc_en && !acc_nwe && in_rng && nrst;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_d = stall_q;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        nwe_d   = nwe_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        if (!ZERO_WAIT) begin
            case (state_q)
                IDLE: if (accept) begin
                    state_d = BUSY;
                    stall_d = 1'b1;
                    cnt_d   = CNT_INIT;
                    nwe_d   = bus.nwe;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    wmask_d = bus.wmask;
                end
                BUSY: if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                    stall_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
        if (acc_en) begin
            err_d = !in_rng;
            if (acc_nwe) rdata_d = in_rng ? mem_rd : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= (mem[idx] & ~acc_wmask) | (acc_wdata & acc_wmask);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            nwe_q   <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            nwe_q   <= nwe_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.stall = stall_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_riscv32ima_mem_resp.sv
// Scoreboard bench: four responders with different wait/base settings, driven
// by directed and random traffic against a word-array reference model.
module tb_riscv32ima_mem_resp;
    localparam int NDUT = 4;
    localparam int          WAIT_P  [NDUT] = '{0, 2, 3, 1};
    localparam int          DEPTH_P [NDUT] = '{1024, 1024, 1024, 64};
    localparam logic [31:0] BASE_P  [NDUT] = '{32'h0, 32'h0, 32'h0, 32'h0000_4000};

    typedef struct {
        logic        is_rd;
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        nrst_a  [NDUT];
    logic        ncs_a   [NDUT];
    logic        nwe_a   [NDUT];
    logic [31:0] addr_a  [NDUT];
    logic [63:0] wdata_a [NDUT];
    logic [63:0] wmask_a [NDUT];
    logic [63:0] rdata_a [NDUT];
    logic        stall_a [NDUT];
    logic        err_a   [NDUT];

    int checks = 0;
    int errors = 0;

    exp_t        sbq [NDUT][$];
    logic [63:0] mdl [longint];
    int unsigned acc_cnt  [NDUT];
    int unsigned done_cnt [NDUT];
    int          stall_run[NDUT];
    logic [63:0] hold     [NDUT];

    always #5 clk = ~clk;

    for (genvar i = 0; i < NDUT; i++) begin : g_dut
        riscv32ima_mem_resp_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) bus ();
        assign bus.ncs   = ncs_a[i];
        assign bus.nwe   = nwe_a[i];
        assign bus.addr  = addr_a[i];
        assign bus.wdata = wdata_a[i];
        assign bus.wmask = wmask_a[i];
        assign rdata_a[i] = bus.rdata;
        assign stall_a[i] = bus.stall;
        assign err_a[i]   = bus.err;
        riscv32ima_mem_resp #(
            .ADDR_WIDTH(32), .DATA_WIDTH(64), .DEPTH(DEPTH_P[i]),
            .BASE_ADDR(BASE_P[i]), .WAIT_CYCLES(WAIT_P[i])
        ) dut (
            .clk (clk),
            .nrst(nrst_a[i]),
            .bus (bus)
        );
    end

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %h want %h at %0t", nm, k, act, exp, $time);
        end
    endtask

    function automatic bit in_rng(input int k, input logic [31:0] a);
        longint b  = longint'(BASE_P[k]);
        longint aa = longint'(a);
        return (aa >= b) && (aa < b + longint'(DEPTH_P[k]) * 8);
    endfunction

    // Reference: a word array per instance keyed by (instance, word index).
    task automatic model(input int k, input logic wn, input logic [31:0] a,
                         input logic [63:0] wd, input logic [63:0] wm);
        exp_t   e;
        bit     inr = in_rng(k, a);
        longint key = (longint'(k) << 40) | ((longint'(a) - longint'(BASE_P[k])) / 8);
        logic [63:0] old;
        e.is_rd = wn;
        e.err   = !inr;
        e.rdata = 64'h0;
        if (inr) begin
            if (!wn) begin
                old = mdl.exists(key) ? mdl[key] : 64'h0;
                mdl[key] = (old & ~wm) | (wd & wm);
            end else begin
                e.rdata = mdl.exists(key) ? mdl[key] : 64'hx;
            end
        end
        sbq[k].push_back(e);
    endtask

    task automatic req(input int k, input logic wn, input logic [31:0] a,
                       input logic [63:0] wd, input logic [63:0] wm, input bit push);
        int t = 0;
        @(negedge clk);
        ncs_a[k] = 1'b0; nwe_a[k] = wn; addr_a[k] = a; wdata_a[k] = wd; wmask_a[k] = wm;
        while (stall_a[k] === 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++; errors++;
            $display("FAIL accept_timeout dut%0d got stall=1 want stall=0", k);
        end
        @(posedge clk);
        if (push) model(k, wn, a, wd, wm);
    endtask

    task automatic idle(input int k, input int n);
        repeat (n) begin
            @(negedge clk);
            ncs_a[k] = 1'b1; nwe_a[k] = 1'($urandom);
            addr_a[k] = $urandom; wdata_a[k] = {$urandom, $urandom}; wmask_a[k] = {$urandom, $urandom};
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            if (!nrst_a[k]) acc_cnt[k] = done_cnt[k];
            else if (!ncs_a[k] && !stall_a[k]) acc_cnt[k]++;
        end
    end

    // Response appears in the first stall-free cycle after an accepted access.
    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] exp_rd;
        for (int k = 0; k < NDUT; k++) begin
            if (!nrst_a[k]) begin
                hold[k] = 64'h0;
                stall_run[k] = 0;
            end else if (acc_cnt[k] != done_cnt[k]) begin
                if (stall_a[k]) stall_run[k]++;
                else begin
                    done_cnt[k]++;
                    if (sbq[k].size() == 0) begin
                        checks++; errors++;
                        $display("FAIL sb_underflow dut%0d got response want none", k);
                    end else begin
                        e = sbq[k].pop_front();
                        exp_rd = e.is_rd ? e.rdata : hold[k];
                        chk("rdata", k, rdata_a[k], exp_rd);
                        chk("err", k, 64'(err_a[k]), 64'(e.err));
                        chk("stall_len", k, 64'(stall_run[k]), 64'(WAIT_P[k]));
                        hold[k] = exp_rd;
                    end
                    stall_run[k] = 0;
                end
            end else begin
                chk("idle_stall", k, 64'(stall_a[k]), 64'h0);
                chk("idle_err", k, 64'(err_a[k]), 64'h0);
                chk("idle_rdata", k, rdata_a[k], hold[k]);
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [63:0] wm;
        for (int k = 0; k < NDUT; k++) begin
            nrst_a[k] = 1'b0; ncs_a[k] = 1'b1; nwe_a[k] = 1'b1;
            addr_a[k] = '0; wdata_a[k] = '0; wmask_a[k] = '0;
            acc_cnt[k] = 0; done_cnt[k] = 0; stall_run[k] = 0; hold[k] = '0;
        end
        @(posedge clk); #1;
        for (int k = 0; k < NDUT; k++) begin
            chk("rst_stall", k, 64'(stall_a[k]), 64'h0);
            chk("rst_rdata", k, rdata_a[k], 64'h0);
            chk("rst_err", k, 64'(err_a[k]), 64'h0);
        end
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) nrst_a[k] = 1'b1;

        // Fill a 16-word window (plus the last word of the small instance).
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < 16; i++)
                req(k, 1'b0, BASE_P[k] + 32'(i * 8), {$urandom, $urandom}, '1, 1);
            if (k == 3) req(k, 1'b0, 32'h0000_41F8, {$urandom, $urandom}, '1, 1);
            idle(k, 1);
        end

        // Full write, read-back, masked write, read with low address bits set.
        req(0, 1'b0, 32'h10, 64'h1122334455667788, '1, 1);
        req(0, 1'b1, 32'h10, '0, '0, 1);
        req(0, 1'b0, 32'h10, 64'hAAAAAAAABBBBBBBB, 64'h00000000FFFFFFFF, 1);
        req(0, 1'b1, 32'h13, '0, '0, 1);
        idle(0, 1);

        // Back-to-back reads through the wait states.
        req(1, 1'b1, 32'h10, '0, '0, 1);
        req(1, 1'b1, 32'h18, '0, '0, 1);
        idle(1, 1);

        // Out-of-range read and write leave the array alone and pulse err.
        for (int k = 0; k < 2; k++) begin
            req(k, 1'b1, 32'h2000, '0, '0, 1);
            req(k, 1'b0, 32'h2000, {$urandom, $urandom}, '1, 1);
            req(k, 1'b1, 32'h0, '0, '0, 1);
            idle(k, 1);
        end
        req(3, 1'b1, 32'h0000_3FF8, '0, '0, 1);
        req(3, 1'b0, 32'h0000_3FF8, 64'h1, '1, 1);
        req(3, 1'b1, 32'h0000_4000, '0, '0, 1);
        req(3, 1'b1, 32'h0000_41FF, '0, '0, 1);
        req(3, 1'b0, 32'h0000_4200, 64'h2, '1, 1);
        req(3, 1'b1, 32'h0000_4200, '0, '0, 1);
        req(3, 1'b1, 32'hFFFF_FFF8, '0, '0, 1);
        idle(3, 1);

        // Random traffic within the initialised window, with some stray addresses.
        for (int k = 0; k < NDUT; k++) begin
            for (int n = 0; n < 60; n++) begin
                if ($urandom_range(7) == 0)
                    a = (k == 3) ? (($urandom_range(1) == 0) ? 32'h0000_3FF8 + 32'($urandom_range(7))
                                                             : 32'h0000_4200 + 32'($urandom_range(255)))
                                 : 32'h0000_2000 + 32'($urandom_range(4095));
                else
                    a = BASE_P[k] + 32'($urandom_range(15) * 8 + $urandom_range(7));
                wm = ($urandom_range(2) == 0) ? '1 : {$urandom, $urandom};
                req(k, 1'($urandom), a, {$urandom, $urandom}, wm, 1);
                if ($urandom_range(3) == 0) idle(k, 1 + $urandom_range(1));
            end
            idle(k, 1);
        end

        // Reset during the second stall cycle drops the pending write.
        req(2, 1'b0, 32'h20, 64'hDEAD, '1, 0);
        @(negedge clk);
        ncs_a[2] = 1'b1;
        @(posedge clk);
        #2 nrst_a[2] = 1'b0;
        #1;
        chk("mid_rst_stall", 2, 64'(stall_a[2]), 64'h0);
        chk("mid_rst_rdata", 2, rdata_a[2], 64'h0);
        chk("mid_rst_err", 2, 64'(err_a[2]), 64'h0);
        @(negedge clk);
        @(negedge clk);
        nrst_a[2] = 1'b1;
        req(2, 1'b1, 32'h20, '0, '0, 1);
        idle(2, 1);

        // Deselected bus activity must change nothing.
        repeat (10) begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                ncs_a[k] = 1'b1; nwe_a[k] = 1'($urandom);
                addr_a[k] = BASE_P[k] + 32'($urandom_range(127));
                wdata_a[k] = {$urandom, $urandom}; wmask_a[k] = '1;
            end
        end
        for (int k = 0; k < NDUT; k++) begin
            req(k, 1'b1, BASE_P[k] + 32'h10, '0, '0, 1);
            req(k, 1'b1, BASE_P[k] + 32'h20, '0, '0, 1);
            idle(k, 1);
        end

        repeat (8) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk("drain_pending", k, 64'(acc_cnt[k] - done_cnt[k]), 64'h0);
            chk("drain_queue", k, 64'(sbq[k].size()), 64'h0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
